// File: rtl/ecc3des_pkg.sv
// Shared widths, defaults and state encoding for the ECDH / 3DES session controller.
package ecc3des_pkg;

  localparam int unsigned PointW   = 164;
  localparam int unsigned KeyW     = 192;
  // Bits of the y coordinate appended to x to fill the key bundle.
  localparam int unsigned KeyTailW = KeyW - PointW;
  localparam int unsigned CountW   = 32;

  localparam int unsigned EccTimeoutDef = 200000;
  localparam int unsigned MaxBlocksDef  = 32'd1 << 20;

  typedef enum logic [3:0] {
    StIdle,
    StGenPub,
    StWaitPub,
    StPubRdy,
    StGenShr,
    StWaitShr,
    StKeyLoad,
    StStream,
    StFault
  } sess_state_e;

  // Busy covers every state where the controller owns the multiplier or a handshake.
  function automatic logic state_is_busy(input sess_state_e st);
    return !(st inside {StIdle, StStream, StFault});
  endfunction

endpackage

// File: rtl/ecc_watchdog.sv
// Cycle counter bounding one point multiplication.
module ecc_watchdog
  import ecc3des_pkg::*;
#(
  parameter int unsigned Timeout = EccTimeoutDef
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(Timeout + 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  // Count cycles since the start pulse; the pulse cycle itself is cycle 0, so the
  // first waiting cycle reads 1. Saturates at Timeout.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = CntW'(1);
    end else if (enable && (cnt_q < CntW'(Timeout))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High in the waiting cycle whose closing edge brings the count to Timeout.
  assign expired = enable && !clear && (cnt_q >= CntW'(Timeout - 1));

endmodule

// File: rtl/ecdh_session_ctrl.sv
// ECDH key-exchange sequencer feeding a 3DES core with per-key block budgeting.
// Registered outputs are loaded on entry to the state that presents them.
module ecdh_session_ctrl
  import ecc3des_pkg::*;
#(
  parameter int unsigned ECC_TIMEOUT = EccTimeoutDef,
  parameter int unsigned MAX_BLOCKS  = MaxBlocksDef
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              sess_start,
  input  logic              abort,
  input  logic [PointW-1:0] k,
  input  logic [PointW-1:0] gx,
  input  logic [PointW-1:0] gy,
  input  logic [PointW-1:0] peer_x,
  input  logic [PointW-1:0] peer_y,
  input  logic              peer_valid,
  output logic              ecc_start,
  output logic [PointW-1:0] ecc_x,
  output logic [PointW-1:0] ecc_y,
  input  logic              ecc_done,
  input  logic [PointW-1:0] ecc_rx,
  input  logic [PointW-1:0] ecc_ry,
  output logic [PointW-1:0] pub_x,
  output logic [PointW-1:0] pub_y,
  output logic              pub_valid,
  output logic [KeyW-1:0]   des_keys,
  output logic              keys_valid,
  input  logic              blk_valid_in,
  output logic              des_valid_in,
  output logic [CountW-1:0] blk_count,
  output logic              busy,
  output logic              error
);

  localparam logic [CountW-1:0] MaxBlk = CountW'(MAX_BLOCKS);

  sess_state_e       state_q;
  logic              ecc_start_q;
  logic [PointW-1:0] ecc_x_q, ecc_y_q;
  logic [PointW-1:0] pub_x_q, pub_y_q;
  logic [PointW-1:0] peer_x_q, peer_y_q;
  logic              pub_valid_q, keys_valid_q, error_q;
  logic [KeyW-1:0]   des_keys_q;
  logic [CountW-1:0] blk_count_q;

  logic start_xchg, peer_zero, blk_room, wd_enable, wd_expired;

  // The scalar belongs to the multiplier side; the upper y bits never reach the key.
  logic unused_ok;
  assign unused_ok = ^{k, ecc_ry[PointW-1:KeyTailW]};

  // sess_start is honoured only where no exchange is in flight.
  assign start_xchg = sess_start && (state_q inside {StIdle, StStream, StFault});
  assign peer_zero  = (peer_x == '0) && (peer_y == '0);
  assign blk_room   = blk_count_q < MaxBlk;
  assign wd_enable  = state_q inside {StWaitPub, StWaitShr};

  ecc_watchdog #(
    .Timeout(ECC_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (ecc_start_q),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // Session FSM with all registered outputs; abort outranks every other event.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q      <= StIdle;
      ecc_start_q  <= 1'b0;
      ecc_x_q      <= '0;
      ecc_y_q      <= '0;
      pub_x_q      <= '0;
      pub_y_q      <= '0;
      peer_x_q     <= '0;
      peer_y_q     <= '0;
      pub_valid_q  <= 1'b0;
      keys_valid_q <= 1'b0;
      error_q      <= 1'b0;
      des_keys_q   <= '0;
      blk_count_q  <= '0;
    end else begin
      ecc_start_q <= 1'b0;
      if (abort) begin
        state_q      <= StIdle;
        pub_valid_q  <= 1'b0;
        keys_valid_q <= 1'b0;
        blk_count_q  <= '0;
      end else if (start_xchg) begin
        state_q      <= StGenPub;
        ecc_start_q  <= 1'b1;
        ecc_x_q      <= gx;
        ecc_y_q      <= gy;
        error_q      <= 1'b0;
        pub_valid_q  <= 1'b0;
        keys_valid_q <= 1'b0;
        blk_count_q  <= '0;
      end else begin
        unique case (state_q)
          StGenPub: state_q <= StWaitPub;
          StWaitPub: begin
            if (ecc_done) begin
              pub_x_q     <= ecc_rx;
              pub_y_q     <= ecc_ry;
              pub_valid_q <= 1'b1;
              state_q     <= StPubRdy;
            end else if (wd_expired) begin
              error_q      <= 1'b1;
              pub_valid_q  <= 1'b0;
              keys_valid_q <= 1'b0;
              state_q      <= StFault;
            end
          end
          StPubRdy: begin
            if (peer_valid) begin
              if (peer_zero) begin
                error_q      <= 1'b1;
                pub_valid_q  <= 1'b0;
                keys_valid_q <= 1'b0;
                state_q      <= StFault;
              end else begin
                peer_x_q    <= peer_x;
                peer_y_q    <= peer_y;
                ecc_x_q     <= peer_x;
                ecc_y_q     <= peer_y;
                ecc_start_q <= 1'b1;
                state_q     <= StGenShr;
              end
            end
          end
          StGenShr: state_q <= StWaitShr;
          StWaitShr: begin
            // Capture the shared point while the multiplier still presents it.
            if (ecc_done) begin
              des_keys_q   <= {ecc_rx, ecc_ry[KeyTailW-1:0]};
              keys_valid_q <= 1'b1;
              blk_count_q  <= '0;
              state_q      <= StKeyLoad;
            end else if (wd_expired) begin
              error_q      <= 1'b1;
              pub_valid_q  <= 1'b0;
              keys_valid_q <= 1'b0;
              state_q      <= StFault;
            end
          end
          StKeyLoad: state_q <= StStream;
          StStream: begin
            if (!blk_room) begin
              // Key budget spent: rekey against the same peer point.
              keys_valid_q <= 1'b0;
              ecc_x_q      <= peer_x_q;
              ecc_y_q      <= peer_y_q;
              ecc_start_q  <= 1'b1;
              state_q      <= StGenShr;
            end else if (des_valid_in) begin
              blk_count_q <= blk_count_q + 1'b1;
            end
          end
          StIdle, StFault: state_q <= state_q;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign des_valid_in = (state_q == StStream) && blk_valid_in && blk_room;
  assign busy         = state_is_busy(state_q);
  assign ecc_start    = ecc_start_q;
  assign ecc_x        = ecc_x_q;
  assign ecc_y        = ecc_y_q;
  assign pub_x        = pub_x_q;
  assign pub_y        = pub_y_q;
  assign pub_valid    = pub_valid_q;
  assign des_keys     = des_keys_q;
  assign keys_valid   = keys_valid_q;
  assign blk_count    = blk_count_q;
  assign error        = error_q;

endmodule

// File: doc/ecdh_session_ctrl.md
ECDH_SESSION_CTRL -- requirements
Module: ecdh_session_ctrl

Interface
REQ-001 Parameter ECC_TIMEOUT, default 200000: maximum cycles allowed between ecc_start and ecc_done.
REQ-002 Parameter MAX_BLOCKS, default 2^20: number of 3DES blocks allowed per session key.
REQ-003 clk  in  1  the single clock; all logic is on the rising edge.
REQ-004 n_rst  in  1  reset; synchronous, active-high (1 resets on the next clk edge).
REQ-005 sess_start  in  1  one-cycle pulse; begins a key-exchange session.
REQ-006 abort  in  1  level input; aborts the session and returns to IDLE.
REQ-007 k  in  164  private scalar.
REQ-008 gx, gy  in  164 each  base point.
REQ-009 peer_x, peer_y, peer_valid  in  164/164/1  peer public point and its qualifier.
REQ-010 ecc_start  out  1  one-cycle start pulse to the point multiplier.
REQ-011 ecc_x, ecc_y  out  164 each  operand point presented to the multiplier.
REQ-012 ecc_done  in  1  multiplier completion pulse.
REQ-013 ecc_rx, ecc_ry  in  164 each  multiplier result point.
REQ-014 pub_x, pub_y, pub_valid  out  164/164/1  own public point and its qualifier.
REQ-015 des_keys, keys_valid  out  192/1  3DES key bundle and its qualifier.
REQ-016 blk_valid_in  in  1  a host data block is offered.
REQ-017 des_valid_in  out  1  gated block-valid to the 3DES core.
REQ-018 blk_count  out  32  number of blocks accepted under the current key.
REQ-019 busy, error  out  1 each  status flags.

Function
REQ-020 The FSM SHALL have the states IDLE, GEN_PUB, WAIT_PUB, PUB_RDY, GEN_SHR, WAIT_SHR, KEY_LOAD, STREAM and FAULT.
REQ-021 IDLE: sess_start=1 SHALL go to GEN_PUB and clear error, pub_valid, keys_valid and blk_count.
REQ-022 GEN_PUB SHALL drive ecc_x=gx and ecc_y=gy, assert ecc_start for exactly one cycle, then go to WAIT_PUB.
REQ-023 WAIT_PUB: on ecc_done=1 it SHALL register pub_x=ecc_rx and pub_y=ecc_ry, set pub_valid=1 and go to PUB_RDY.
REQ-024 PUB_RDY: on peer_valid=1 it SHALL latch peer_x and peer_y internally and go to GEN_SHR.
REQ-025 A peer point of (0,0) SHALL go to FAULT instead of GEN_SHR.
REQ-026 GEN_SHR SHALL drive the latched peer point on ecc_x/ecc_y, pulse ecc_start once, then go to WAIT_SHR.
REQ-027 WAIT_SHR: on ecc_done=1 it SHALL go to KEY_LOAD.
REQ-028 KEY_LOAD SHALL set des_keys={ecc_rx[163:0], ecc_ry[27:0]} and keys_valid=1, clear blk_count, then go to STREAM.
REQ-029 KEY_LOAD SHALL last exactly one cycle.
REQ-030 STREAM: des_valid_in SHALL equal blk_valid_in while blk_count<MAX_BLOCKS and 0 otherwise.
REQ-031 blk_count SHALL increment on each cycle where des_valid_in=1 and saturate at MAX_BLOCKS.
REQ-032 STREAM: when blk_count reaches MAX_BLOCKS it SHALL deassert keys_valid and go to GEN_SHR (automatic rekey with the same peer point).
REQ-033 During the rekey, pub_valid SHALL stay 1.
REQ-034 STREAM: sess_start=1 SHALL go to GEN_PUB for a full new exchange.
REQ-035 A cycle counter SHALL clear on every ecc_start pulse and count in WAIT_PUB/WAIT_SHR.
REQ-036 When the cycle counter reaches ECC_TIMEOUT before ecc_done, the FSM SHALL go to FAULT.
REQ-037 ecc_done received outside WAIT_PUB/WAIT_SHR SHALL be ignored.
REQ-038 FAULT SHALL set error=1 and clear pub_valid and keys_valid.
REQ-039 FAULT SHALL be left only on sess_start (to GEN_PUB) or abort (to IDLE).
REQ-040 abort=1 in any state SHALL go to IDLE next cycle and clear pub_valid, keys_valid, des_valid_in and blk_count; error is unchanged.
REQ-041 abort SHALL take priority over every other event in the same cycle.
REQ-042 sess_start in WAIT_PUB, WAIT_SHR, GEN_* or PUB_RDY SHALL be ignored.
REQ-043 busy SHALL be 1 in every state except IDLE, STREAM and FAULT.
REQ-044 des_valid_in SHALL be 0 in every state other than STREAM.

Reset
REQ-045 n_rst=1 SHALL force IDLE on the next edge.
REQ-046 Reset SHALL set ecc_start, pub_valid, keys_valid, des_valid_in, busy and error to 0.
REQ-047 Reset SHALL set blk_count and the cycle counter to 0.
REQ-048 Reset SHALL set pub_x, pub_y, des_keys and ecc_x/ecc_y to 0.
REQ-049 Reset mid-operation SHALL leave no pending ecc_start.

Structure
REQ-050 The state enum, the 164/192 width constants and the ECC_TIMEOUT/MAX_BLOCKS defaults SHALL live in the shared package ecc3des_pkg.
REQ-051 The timeout counter SHALL be a sub-module, ecc_watchdog (inputs clear, enable; output expired).

Verification
REQ-052 Full exchange: sess_start, model ecc_done after 50 cycles, peer_valid after 10 -> exactly 2 ecc_start pulses, pub_valid=1 after the first ecc_done, keys_valid=1 exactly one cycle after the second ecc_done, des_keys equal to the formula in REQ-028.
REQ-053 Streaming: MAX_BLOCKS=4, blk_valid_in held high -> 4 des_valid_in pulses, then keys_valid=0 and a third ecc_start, with blk_count reading 4 then 0.
REQ-054 Timeout: ECC_TIMEOUT=100 and ecc_done never arrives -> FAULT with error=1 at cycle 100 after ecc_start; a later sess_start recovers.
REQ-055 abort asserted in WAIT_SHR together with ecc_done -> IDLE, keys_valid stays 0, error unchanged.
REQ-056 Peer point (0,0) -> FAULT, and no second ecc_start is issued.
REQ-057 n_rst=1 asserted in STREAM -> all outputs zero on the next edge; an ecc_done pulse afterwards is ignored.
